// File: rtl/uart_tx_framer.sv
// uart_tx_framer: standalone UART transmitter. Each byte taken through the
// valid/ready handshake is sent as one asynchronous frame:
//   start bit (low), DATA_BITS data bits LSB first, optional parity,
//   STOP_BITS stop bits (high).
// Every bit lasts exactly CLKS_PER_BIT cycles of CLK.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit(s).
//
// Ports:
//   CLK       system clock, rising edge
//   RST       synchronous active-high reset
//   TX_DATA   byte to send; only [DATA_BITS-1:0] are transmitted
//   TX_VALID  host offers TX_DATA
//   TX_READY  byte accepted on this edge if TX_VALID (idle and not in reset)
//   TX        serial line, idles high
//   BUSY      frame in progress
//   DONE      one-cycle pulse in the last cycle of the last stop bit
module uart_tx_framer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       TX,
  output logic       BUSY,
  output logic       DONE
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;    // data bit index, reused as stop bit index
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              bit_end;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign bit_end  = (baud_q == BAUD_LAST);
  assign TX_READY = (state_q == S_IDLE) && !RST;
  assign TX       = tx_q;
  assign BUSY     = (state_q != S_IDLE);
  assign DONE     = (state_q == S_STOP) && bit_end && (bit_q == STOP_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    // Baud counter free-runs inside a frame and is parked at 0 in IDLE.
    if (state_q == S_IDLE) baud_d = '0;
    else                   baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);

    case (state_q)
      S_IDLE: begin
        bit_d = '0;
        if (TX_VALID && TX_READY) begin
          shift_d = TX_DATA;
`ifdef UART_TX_PARITY_EN
          // Parity is taken from the byte as latched, before any shifting.
          parity_d = ^TX_DATA[DATA_BITS-1:0];
`endif
          state_d = S_START;
        end
      end
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_end) state_d = S_STOP;
`endif
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // TX is registered from the next state so the line changes on the same
    // edge the state does, with no decode glitches on the pin.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Testbench for uart_tx_framer. Builds the expected serial waveform of each
// frame as a list of line levels (one per bit period) and compares TX, BUSY,
// DONE and TX_READY on every cycle. Stimulus mixes directed cases with
// random bytes, random back-to-back/gap spacing and random TX_DATA churn.
module tb_uart_tx_framer;

  localparam int CPB = 4;
  localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int SB  = 2;
  localparam int PB  = 1;
`else
  localparam int SB  = 1;
  localparam int PB  = 0;
`endif
  localparam int FRAME_CYC = (1 + DB + PB + SB) * CPB;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_VALID = 1'b0;
  logic       TX_READY, TX, BUSY, DONE;

  int checks = 0;
  int errors = 0;

  uart_tx_framer #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(SB)) dut (
    .CLK(CLK), .RST(RST), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
    .TX_READY(TX_READY), .TX(TX), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Line level per bit period for one byte.
  function automatic void build_frame(input logic [7:0] b, output int lv[$]);
    int ones;
    lv.delete();
    ones = 0;
    lv.push_back(0);
    for (int i = 0; i < DB; i++) begin
      lv.push_back((int'(b) >> i) % 2);
      ones += (int'(b) >> i) % 2;
    end
    if (PB == 1) lv.push_back(ones % 2);
    for (int i = 0; i < SB; i++) lv.push_back(1);
  endfunction

  // Called at a negedge in an idle cycle; the byte is accepted on the next
  // posedge. Returns at the negedge of the idle cycle after the frame.
  // hold keeps TX_VALID high throughout; chg_cyc/chg_val disturb TX_DATA.
  task automatic frame(input logic [7:0] b, input bit hold,
                       input int chg_cyc, input logic [7:0] chg_val);
    int lv[$];
    int busy_cnt, done_cnt;
    build_frame(b, lv);
    TX_DATA  = b;
    TX_VALID = 1'b1;
    chk("ready_pre", 32'(TX_READY), 32'd1);
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 1; k <= lv.size() * CPB; k++) begin
      @(negedge CLK);
      chk("tx", 32'(TX), 32'(lv[(k - 1) / CPB]));
      chk("done", 32'(DONE), 32'(k == FRAME_CYC));
      chk("ready_busy", 32'(TX_READY), 32'd0);
      busy_cnt += int'(BUSY);
      done_cnt += int'(DONE);
      if (k == 1 && !hold) TX_VALID = 1'b0;
      if (k == chg_cyc) TX_DATA = chg_val;
    end
    chk("busy_len", 32'(busy_cnt), 32'(FRAME_CYC));
    chk("done_cnt", 32'(done_cnt), 32'd1);
    @(negedge CLK);
    chk("idle_tx", 32'(TX), 32'd1);
    chk("idle_busy", 32'(BUSY), 32'd0);
    chk("idle_done", 32'(DONE), 32'd0);
    chk("idle_ready", 32'(TX_READY), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    TX_VALID = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      chk("gap_tx", 32'(TX), 32'd1);
      chk("gap_busy", 32'(BUSY), 32'd0);
      chk("gap_done", 32'(DONE), 32'd0);
    end
  endtask

  initial begin
    // Reset held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (i > 0) begin
        chk("rst_tx", 32'(TX), 32'd1);
        chk("rst_ready", 32'(TX_READY), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
      end
    end
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_ready", 32'(TX_READY), 32'd1);
    chk("post_rst_busy", 32'(BUSY), 32'd0);
    chk("post_rst_done", 32'(DONE), 32'd0);
    chk("post_rst_tx", 32'(TX), 32'd1);

    // Single byte, then parity/stop case byte.
    frame(8'hA5, 1'b0, 0, 8'h00);
    idle_cycles(2);
    frame(8'h07, 1'b0, 0, 8'h00);
    idle_cycles(1);

    // Back-to-back with TX_VALID held: one idle cycle between frames.
    frame(8'h00, 1'b1, 0, 8'h00);
    frame(8'hFF, 1'b0, 0, 8'h00);
    idle_cycles(1);

    // TX_DATA changed two cycles after accept.
    frame(8'h3C, 1'b0, 2, 8'hC3);
    idle_cycles(1);

    // Reset during data bit 3 of 0x55 (frame cycles 17..20).
    TX_DATA  = 8'h55;
    TX_VALID = 1'b1;
    @(negedge CLK);
    TX_VALID = 1'b0;
    for (int k = 2; k <= 18; k++) @(negedge CLK);
    chk("pre_abort_busy", 32'(BUSY), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_tx", 32'(TX), 32'd1);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_done", 32'(DONE), 32'd0);
    chk("abort_ready", 32'(TX_READY), 32'd0);
    RST = 1'b0;
    idle_cycles(FRAME_CYC + 4);
    frame(8'h55, 1'b0, 0, 8'h00);

    // Random bytes, spacing and TX_DATA churn.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b, c;
      bit hold;
      b    = 8'($urandom);
      c    = 8'($urandom);
      hold = 1'($urandom_range(0, 1));
      frame(b, hold, int'($urandom_range(1, FRAME_CYC)), c);
      if (!hold) idle_cycles(int'($urandom_range(0, 3)));
    end
    TX_VALID = 1'b0;
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
